// File: rtl/tc_pe_ctrl_if.sv
// Host-side bundle for the PE-array sequencer: job request, operand fetch
// strobe, PE product return and result handshake.
interface tc_pe_ctrl_if #(
  parameter int N_UNIT  = 64,
  parameter int DW_DATA = 32,
  parameter int DW_LEN  = 8
);
  logic                        start;
  logic [DW_LEN-1:0]           len;
  logic                        busy;
  logic                        op_rd_en;
  logic [DW_LEN-1:0]           op_rd_addr;
  logic [N_UNIT*DW_DATA-1:0]   pe_out;
  logic [N_UNIT*DW_DATA-1:0]   acc_out;
  logic                        out_valid;
  logic                        out_ready;

  // Host / PE-array / downstream side.
  modport master (
    output start, len, pe_out, out_ready,
    input  busy, op_rd_en, op_rd_addr, acc_out, out_valid
  );

  // Sequencer side.
  modport slave (
    input  start, len, pe_out, out_ready,
    output busy, op_rd_en, op_rd_addr, acc_out, out_valid
  );
endinterface

// File: rtl/tc_pe_ctrl.sv
// PE-array job sequencer: issues len consecutive operand fetches, tracks the
// fixed fetch-to-product latency with a valid shift register, accumulates the
// returned lane products and hands the per-lane sums downstream.
module tc_pe_ctrl #(
  parameter int N_UNIT  = 64,
  parameter int DW_DATA = 32,
  parameter int DW_LEN  = 8,
  parameter int LAT     = 2
) (
  input  logic         clk,
  input  logic         reset,
  tc_pe_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [DW_LEN-1:0]               r_len;
  logic [DW_LEN-1:0]               r_addr;
  logic [LAT-1:0]                  r_vld_sr;
  logic [LAT-1:0]                  w_vld_sr_nxt;
  logic [N_UNIT-1:0][DW_DATA-1:0]  r_acc;

  logic w_issue;
  logic w_start_job;
  logic w_last_addr;
  logic w_vld_out;

  assign w_issue      = (r_state == S_ISSUE);
  assign w_start_job  = (r_state == S_IDLE) && bus.start;
  assign w_last_addr  = (r_addr == r_len - DW_LEN'(1));
  // Delayed copy of the fetch strobe; its top bit marks a valid pe_out.
  assign w_vld_sr_nxt = (r_vld_sr << 1) | LAT'(w_issue);
  assign w_vld_out    = r_vld_sr[LAT-1];

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode; DRAIN exits once the last in-flight product lands.
  always_comb begin
    // NOTE: default first so no path through the case leaves it unassigned,
    // which would otherwise infer a latch.
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = (bus.len == '0) ? S_OUT : S_ISSUE;
      S_ISSUE: if (w_last_addr) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_vld_sr_nxt == '0) w_state_nxt = S_OUT;
      S_OUT:   if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs; the fetch address is forced to zero outside ISSUE.
  always_comb begin
    bus.busy       = (r_state != S_IDLE);
    bus.op_rd_en   = w_issue;
    bus.op_rd_addr = w_issue ? r_addr : '0;
    bus.out_valid  = (r_state == S_OUT);
  end

  // Job length, fetch address and latency tracker.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_len    <= '0;
      r_addr   <= '0;
      r_vld_sr <= '0;
    end else begin
      r_vld_sr <= w_vld_sr_nxt;
      if (w_start_job) begin
        r_len  <= bus.len;
        r_addr <= '0;
      end else if (w_issue && !w_last_addr) begin
        r_addr <= r_addr + DW_LEN'(1);
      end
    end
  end

  // Per-lane accumulators: cleared at job start, summed on delayed valid.
  always_ff @(posedge clk) begin
    // NOTE: the accumulator bank is reset explicitly because a mid-job abort
    // must leave acc_out at zero, not just the control state.
    if (reset) begin
      r_acc <= '0;
    end else if (w_start_job) begin
      r_acc <= '0;
    end else if (w_vld_out) begin
      for (int i = 0; i < N_UNIT; i++)
        r_acc[i] <= r_acc[i] + bus.pe_out[i*DW_DATA +: DW_DATA];
    end
  end

  assign bus.acc_out = r_acc;

endmodule

// File: tb/tb_tc_pe_ctrl.sv
// Scoreboard bench for tc_pe_ctrl: a PE model returns products LAT cycles
// after each fetch, the stimulus pushes hand-computed job results and a
// negedge monitor checks fetch addresses, latency and every delivered result.
module tb_tc_pe_ctrl;

  localparam int N   = 64;
  localparam int DW  = 32;
  localparam int DL  = 8;
  localparam int LAT = 2;
  localparam int W   = N * DW;

  typedef struct {
    int           len;
    logic [W-1:0] acc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tc_pe_ctrl_if #(.N_UNIT(N), .DW_DATA(DW), .DW_LEN(DL)) bus ();

  tc_pe_ctrl #(.N_UNIT(N), .DW_DATA(DW), .DW_LEN(DL), .LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  exp_t sb_q[$];
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   n_pushed  = 0;
  int   n_results = 0;

  // Product generator settings for the current job.
  logic [31:0] g_val, g_mul, g_step, g_l0v;
  bit          g_l0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Compares a whole result vector, reporting the first differing lane.
  task automatic check_acc(string name, logic [W-1:0] act, logic [W-1:0] exp);
    int idx = 0;
    for (int i = N - 1; i >= 0; i--)
      if (act[i*DW +: DW] !== exp[i*DW +: DW]) idx = i;
    check($sformatf("%s lane %0d", name, idx),
          64'(act[idx*DW +: DW]), 64'(exp[idx*DW +: DW]));
  endtask

  // Expected result: lane i = c + m*i, lane 0 optionally overridden.
  function automatic logic [W-1:0] mk_exp(logic [31:0] c, logic [31:0] m,
                                          bit l0, logic [31:0] l0v);
    logic [W-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = c + m * 32'(i);
    if (l0) v[DW-1:0] = l0v;
    return v;
  endfunction

  // PE array model: product for a fetch appears LAT cycles later; outside
  // those cycles the lanes carry junk that must never be accumulated.
  logic          pipe_v [LAT+1];
  logic [DL-1:0] pipe_a [LAT+1];
  always @(negedge clk) begin
    logic [W-1:0] v;
    for (int i = LAT; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_a[i] = pipe_a[i-1];
    end
    pipe_v[0] = bus.op_rd_en;
    pipe_a[0] = bus.op_rd_addr;
    for (int i = 0; i < N; i++) begin
      if (pipe_v[LAT] === 1'b1) begin
        if (g_l0 && i == 0) v[i*DW +: DW] = g_l0v + g_step * 32'(pipe_a[LAT]);
        else v[i*DW +: DW] = g_val + g_mul * 32'(i) + g_step * 32'(pipe_a[LAT]);
      end else begin
        v[i*DW +: DW] = 32'hBAD0_0000 | 32'(i);
      end
    end
    bus.pe_out = v;
  end

  // Monitor: fetch sequence, fetch-to-result latency, result scoreboard.
  int cyc = 0, last_fetch = 0, exp_addr = 0, fetches = 0;
  bit prev_valid = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (bus.op_rd_en === 1'b1) begin
      check("op_rd_addr", 64'(bus.op_rd_addr), 64'(exp_addr));
      exp_addr++;
      fetches++;
      last_fetch = cyc;
    end else begin
      check("op_rd_addr outside issue", 64'(bus.op_rd_addr), 64'd0);
      exp_addr = 0;
    end
    if (bus.out_valid === 1'b1 && !prev_valid && sb_q.size() > 0 && sb_q[0].len > 0)
      check("fetch to out_valid latency", 64'(cyc - last_fetch), 64'(LAT + 1));
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected result, queue depth", 64'(sb_q.size()), 64'd1);
      end else begin
        e = sb_q.pop_front();
        check_acc("result", bus.acc_out, e.acc);
        check("fetch count", 64'(fetches), 64'(e.len));
        n_results++;
      end
      fetches = 0;
    end
    prev_valid = (bus.out_valid === 1'b1);
    if (reset === 1'b1) begin
      fetches    = 0;
      exp_addr   = 0;
      prev_valid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(int budget);
    int k = 0;
    while (bus.busy !== 1'b0 && k < budget) begin
      tick();
      k++;
    end
    if (bus.busy !== 1'b0) check("timeout waiting for idle", 64'(bus.busy), 64'd0);
  endtask

  task automatic wait_valid(int budget);
    int k = 0;
    while (bus.out_valid !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    if (bus.out_valid !== 1'b1) check("timeout waiting for out_valid", 64'(bus.out_valid), 64'd1);
  endtask

  task automatic set_job(logic [31:0] val, logic [31:0] mul, logic [31:0] step,
                         bit l0, logic [31:0] l0v);
    g_val = val; g_mul = mul; g_step = step; g_l0 = l0; g_l0v = l0v;
  endtask

  // Issues one job and registers its expected result; returns one cycle
  // after the start was sampled.
  task automatic start_job(int len, logic [W-1:0] exp_acc);
    exp_t e;
    wait_idle(1000);
    e.len = len;
    e.acc = exp_acc;
    sb_q.push_back(e);
    n_pushed++;
    bus.len   = DL'(len);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic run_vec(int len, logic [31:0] val, logic [31:0] mul, logic [31:0] step,
                         bit l0, logic [31:0] l0v, logic [31:0] ec, logic [31:0] el,
                         logic [31:0] el0);
    set_job(val, mul, step, l0, l0v);
    start_job(len, mk_exp(ec, el, l0, el0));
    wait_idle(1000);
  endtask

  task automatic check_outputs_zero(string tag);
    check({tag, " busy"},       64'(bus.busy),       64'd0);
    check({tag, " op_rd_en"},   64'(bus.op_rd_en),   64'd0);
    check({tag, " op_rd_addr"}, 64'(bus.op_rd_addr), 64'd0);
    check({tag, " out_valid"},  64'(bus.out_valid),  64'd0);
    check_acc({tag, " acc_out"}, bus.acc_out, '0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.out_ready = 1'b1;
    set_job(0, 0, 0, 0, 0);
    repeat (3) tick();
    check_outputs_zero("in reset");
    reset = 1'b0;
    tick();
    check_outputs_zero("after reset");

    // len, val, mul, step, l0, l0v, exp const, exp per-lane, exp lane0
    run_vec(4,   32'd3,          32'd0,          32'd0, 0, 32'd0,          32'd12,         32'd0,          32'd0);
    run_vec(3,   32'd10,         32'd1,          32'd7, 0, 32'd0,          32'd51,         32'd3,          32'd0);
    run_vec(2,   32'd1,          32'd0,          32'd0, 1, 32'hFFFF_FFFF,  32'd2,          32'd0,          32'hFFFF_FFFE);
    run_vec(1,   32'h8000_0000,  32'h4000_0000,  32'd0, 0, 32'd0,          32'h8000_0000,  32'h4000_0000,  32'd0);
    run_vec(255, 32'd1,          32'd0,          32'd2, 0, 32'd0,          32'd65025,      32'd0,          32'd0);

    // Zero-length job goes straight to OUT with cleared accumulators.
    set_job(32'd7, 0, 0, 0, 0);
    start_job(0, '0);
    check("len0 out_valid next cycle", 64'(bus.out_valid), 64'd1);
    check("len0 no fetch", 64'(bus.op_rd_en), 64'd0);
    wait_idle(100);

    // Result held while downstream stalls.
    bus.out_ready = 1'b0;
    set_job(32'h11, 32'h100, 0, 0, 0);
    start_job(2, mk_exp(32'h22, 32'h200, 0, 0));
    wait_valid(100);
    for (int k = 0; k < 5; k++) begin
      check("stall out_valid", 64'(bus.out_valid), 64'd1);
      check_acc("stall acc_out", bus.acc_out, mk_exp(32'h22, 32'h200, 0, 0));
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    check("idle after handshake", 64'(bus.busy), 64'd0);

    // Abort on the second ISSUE cycle, then a clean job.
    set_job(32'd9, 32'd1, 32'd1, 0, 0);
    bus.len   = DL'(8);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("abort at second fetch", 64'(bus.op_rd_addr), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_outputs_zero("after abort");
    run_vec(1, 32'd5, 0, 0, 0, 0, 32'd5, 32'd0, 32'd0);

    // start pulses during ISSUE and OUT are ignored.
    bus.out_ready = 1'b0;
    set_job(32'd2, 0, 0, 0, 0);
    start_job(3, mk_exp(32'd6, 0, 0, 0));
    tick();
    bus.len   = DL'(7);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_valid(100);
    bus.len   = DL'(5);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("out_valid held across start", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    tick();
    repeat (3) tick();
    check("no spurious job", 64'(bus.busy), 64'd0);

    repeat (5) tick();
    check("scoreboard drained", 64'(sb_q.size()), 64'd0);
    check("result count", 64'(n_results), 64'(n_pushed));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
